// File: rtl/trdb_branch_map_pkg.sv
// Shared trace-encoder definitions for the branch-map accumulator:
// default map geometry, the emitted record layout and the lane-count helper.
package trdb_branch_map_pkg;

   localparam int BRANCH_MAP_LEN   = 31;
   localparam int BRANCH_COUNT_LEN = 5;
   localparam int MAX_LANES        = 4;

   typedef struct packed {
      logic [BRANCH_MAP_LEN-1:0]   map;
      logic [BRANCH_COUNT_LEN-1:0] count;
      logic                        full;
   } trdb_branch_rec_t;

   // Number of valid lanes counting up from lane 0; stops at the first gap.
   function automatic logic [2:0] trdb_lane_cnt(input logic [MAX_LANES-1:0] valid);
      logic [2:0] n;
      logic       run;
      n   = '0;
      run = 1'b1;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (run && valid[i]) begin
            n = n + 3'd1;
         end else begin
            run = 1'b0;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/trdb_branch_map.sv
// Multi-lane branch-map accumulator: packs up to N_RET branch outcomes per cycle
// into a MAP_LEN-bit map and emits registered records on fill or flush.
module trdb_branch_map
   import trdb_branch_map_pkg::*;
#(
   parameter int MAP_LEN = BRANCH_MAP_LEN,
   parameter int N_RET   = 2,
   parameter int CNT_W   = $clog2(MAP_LEN + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [N_RET-1:0]   branch_valid_i,
   input  logic [N_RET-1:0]   branch_taken_i,
   input  logic               flush_i,
   output logic               in_ready_o,
   output logic               map_valid_o,
   input  logic               map_ready_i,
   output logic [MAP_LEN-1:0] map_o,
   output logic [CNT_W-1:0]   count_o,
   output logic               full_o
);

   localparam int W     = MAP_LEN + N_RET;
   localparam int SUM_W = CNT_W + 1;
   localparam logic [SUM_W-1:0] FULL_SUM = SUM_W'(MAP_LEN);

   logic [MAP_LEN-1:0] acc_map, acc_map_d;
   logic [CNT_W-1:0]   acc_cnt, acc_cnt_d;
   logic               pend_flush, pend_flush_d;
   trdb_branch_rec_t   rec_q, rec_d;
   logic               map_valid_q, map_valid_d;

   logic [2:0]         lane_n;
   logic [N_RET-1:0]   lane_bits;
   logic [W-1:0]       merged;
   logic [SUM_W-1:0]   sum;
   logic               fill;
   logic               slot_free;
   logic               accept;

   assign slot_free  = !map_valid_q || map_ready_i;
   assign in_ready_o = slot_free && !pend_flush;
   assign accept     = in_ready_o;

   // Map bits store NOT-taken; lanes land at the current fill point, oldest lowest.
   assign lane_n    = trdb_lane_cnt(MAX_LANES'(branch_valid_i));
   assign lane_bits = ~branch_taken_i & branch_valid_i;
   assign merged    = W'(acc_map) | (W'(lane_bits) << acc_cnt);
   assign sum       = SUM_W'(acc_cnt) + SUM_W'(lane_n);
   assign fill      = sum >= FULL_SUM;

   always_comb begin
      acc_map_d    = acc_map;
      acc_cnt_d    = acc_cnt;
      pend_flush_d = pend_flush;
      rec_d        = rec_q;
      map_valid_d  = map_valid_q && !map_ready_i;
      if (accept) begin
         if (fill) begin
            rec_d.map    = BRANCH_MAP_LEN'(merged[MAP_LEN-1:0]);
            rec_d.count  = BRANCH_COUNT_LEN'(MAP_LEN);
            rec_d.full   = 1'b1;
            map_valid_d  = 1'b1;
            // Lanes past the fill point seed the next map; a flush then waits for them.
            acc_map_d    = MAP_LEN'(merged[W-1:MAP_LEN]);
            acc_cnt_d    = CNT_W'(sum - FULL_SUM);
            pend_flush_d = flush_i && (sum != FULL_SUM);
         end else if (flush_i) begin
            rec_d.map    = BRANCH_MAP_LEN'(merged[MAP_LEN-1:0]);
            rec_d.count  = BRANCH_COUNT_LEN'(sum);
            rec_d.full   = 1'b0;
            map_valid_d  = 1'b1;
            acc_map_d    = '0;
            acc_cnt_d    = '0;
         end else begin
            acc_map_d    = merged[MAP_LEN-1:0];
            acc_cnt_d    = CNT_W'(sum);
         end
      end else if (pend_flush && slot_free) begin
         rec_d.map    = BRANCH_MAP_LEN'(acc_map);
         rec_d.count  = BRANCH_COUNT_LEN'(acc_cnt);
         rec_d.full   = 1'b0;
         map_valid_d  = 1'b1;
         acc_map_d    = '0;
         acc_cnt_d    = '0;
         pend_flush_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_map     <= '0;
         acc_cnt     <= '0;
         pend_flush  <= 1'b0;
         rec_q       <= '0;
         map_valid_q <= 1'b0;
      end else begin
         acc_map     <= acc_map_d;
         acc_cnt     <= acc_cnt_d;
         pend_flush  <= pend_flush_d;
         rec_q       <= rec_d;
         map_valid_q <= map_valid_d;
      end
   end

   assign map_valid_o = map_valid_q;
   assign map_o       = rec_q.map[MAP_LEN-1:0];
   assign count_o     = rec_q.count[CNT_W-1:0];
   assign full_o      = rec_q.full;

   // Valid lanes must form a contiguous run starting at lane 0.
   lanes_contiguous: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (branch_valid_i & (branch_valid_i + N_RET'(1))) == '0);

endmodule
